// File: rtl/pu_packer_pkg.sv
// Shared types and width helpers for the PU write packer.
package pu_packer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } pu_state_e;

  function automatic int slot_width(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

  function automatic int count_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// Beat FIFO for the write packer: power-of-two depth, head read straight from storage.
module packer_fifo
  import pu_packer_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so stale or discarded beats never show.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pu_write_packer.sv
// Packs PACK PU words into one memory beat, buffers beats and marks burst ends.
// Optional counters enabled by defining PU_WRITE_PACKER_PERF_EN.
module pu_write_packer
  import pu_packer_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int PACK       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 16,
  localparam int DW = NUM_PE * OP_WIDTH,
  localparam int BW = PACK * DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pu_write_req,
  input  logic [DW-1:0] pu_write_data,
  output logic          pu_write_ready,
  input  logic          flush,
  output logic          flush_done,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [BW-1:0] wr_data,
  output logic          wr_last,
  output logic          busy,
`ifdef PU_WRITE_PACKER_PERF_EN
  output logic [31:0]   stall_cycles,
  output logic [31:0]   beats_out,
`endif
  output logic [1:0]    state_dbg
);

  localparam int SLOT_W = slot_width(PACK);
  localparam int CNT_W  = count_width(BURST_LEN);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN - 1);

  pu_state_e         state;
  logic              run_en;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0]  push_cnt;
  logic [BW-1:0]     pack_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop;
  logic              push;
  logic              push_last;
  logic [BW-1:0]     push_beat;
  logic [BW:0]       fifo_head;

  // Both ports use valid/ready: a transfer happens on a rising edge where both are
  // high; the source holds data stable until then and valid never waits on ready.
  assign pu_write_ready = run_en & (state == RUN) & ~fifo_full;
  assign accept         = pu_write_req & pu_write_ready;
  assign wr_valid       = ~fifo_empty;
  assign pop            = wr_valid & wr_ready;
  assign {wr_last, wr_data} = fifo_head;
  assign busy           = (state != RUN) | ~fifo_empty | (slot != '0);
  assign state_dbg      = state;

  // pack_reg is cleared after every beat, so unfilled slots are already zero padding.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    push_beat = pack_reg;
    case (state)
      RUN: begin
        if (accept && slot == LAST_SLOT) begin
          push = 1'b1;
          push_beat[(PACK-1)*DW +: DW] = pu_write_data;
          push_last = (push_cnt == LAST_CNT);
        end
      end
      PAD: begin
        if (slot != '0) begin
          push      = ~fifo_full;
          push_last = 1'b1;
        end else if (push_cnt != '0) begin
          push      = ~fifo_full;
          push_beat = '0;
          push_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      run_en     <= 1'b0;
      slot       <= '0;
      push_cnt   <= '0;
      pack_reg   <= '0;
      flush_done <= 1'b0;
    end else begin
      run_en     <= 1'b1;
      flush_done <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (slot == LAST_SLOT) begin
              slot     <= '0;
              pack_reg <= '0;
              push_cnt <= (push_cnt == LAST_CNT) ? '0 : push_cnt + 1'b1;
            end else begin
              pack_reg[slot*DW +: DW] <= pu_write_data;
              slot <= slot + 1'b1;
            end
          end
          if (flush) state <= PAD;
        end
        PAD: begin
          if (slot != '0) begin
            if (!fifo_full) begin
              slot     <= '0;
              pack_reg <= '0;
              push_cnt <= '0;
              state    <= DRAIN;
            end
          end else if (push_cnt != '0) begin
            if (!fifo_full) begin
              push_cnt <= '0;
              state    <= DRAIN;
            end
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            flush_done <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  packer_fifo #(
    .WIDTH (BW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_last, push_beat}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef PU_WRITE_PACKER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      beats_out    <= '0;
    end else begin
      if (pu_write_req && !pu_write_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (pop && beats_out != '1)
        beats_out <= beats_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pu_write_packer.sv
// Self-checking bench for pu_write_packer: directed tables, corner sequences, random vs model.
module tb_pu_write_packer;

  localparam int OP_WIDTH   = 16;
  localparam int NUM_PE     = 4;
  localparam int PACK       = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int BURST_LEN  = 4;
  localparam int DW         = NUM_PE * OP_WIDTH;
  localparam int BW         = PACK * DW;

  logic          clk;
  logic          reset;
  logic          pu_write_req;
  logic [DW-1:0] pu_write_data;
  logic          pu_write_ready;
  logic          flush;
  logic          flush_done;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_data;
  logic          wr_last;
  logic          busy;
  logic [1:0]    state_dbg;
`ifdef PU_WRITE_PACKER_PERF_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   beats_out;
`endif

  pu_write_packer #(
    .OP_WIDTH   (OP_WIDTH),
    .NUM_PE     (NUM_PE),
    .PACK       (PACK),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pu_write_req   (pu_write_req),
    .pu_write_data  (pu_write_data),
    .pu_write_ready (pu_write_ready),
    .flush          (flush),
    .flush_done     (flush_done),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .busy           (busy),
`ifdef PU_WRITE_PACKER_PERF_EN
    .stall_cycles   (stall_cycles),
    .beats_out      (beats_out),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] pend_q[$];
  logic [BW:0]   exp_q[$];
  logic [BW:0]   got_q[$];
  int unsigned   burst_pos;
  bit            model_flushing;
  int unsigned   model_stall;
  int unsigned   model_pops;

  int   cyc;
  int   last_pop_cyc;
  int   fd_cyc;
  bit   acc_seen;
  bit   hold_prev;
  logic [BW:0] hold_val;
  logic s_ready, s_valid, s_busy;

  task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A beat is PACK consecutive accepted words, oldest in the LSBs; every
  // BURST_LEN-th beat since the last flush closes a burst.
  function automatic void model_word(input logic [DW-1:0] d);
    logic [BW-1:0] beat;
    logic          last;
    pend_q.push_back(d);
    if (pend_q.size() == PACK) begin
      beat = '0;
      foreach (pend_q[i]) beat[i*DW +: DW] = pend_q[i];
      last = (burst_pos == BURST_LEN - 1);
      exp_q.push_back({last, beat});
      burst_pos = (burst_pos + 1) % BURST_LEN;
      pend_q.delete();
    end
  endfunction

  function automatic void model_flush();
    logic [BW-1:0] beat;
    beat = '0;
    if (pend_q.size() > 0) begin
      foreach (pend_q[i]) beat[i*DW +: DW] = pend_q[i];
      exp_q.push_back({1'b1, beat});
    end else if (burst_pos != 0) begin
      exp_q.push_back({1'b1, beat});
    end
    pend_q.delete();
    burst_pos = 0;
    model_flushing = 1'b1;
  endfunction

  function automatic void model_clear();
    pend_q.delete();
    exp_q.delete();
    got_q.delete();
    burst_pos = 0;
    model_flushing = 1'b0;
    model_stall = 0;
    model_pops = 0;
    hold_prev = 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic req, input logic [DW-1:0] d, input logic rdy, input logic fl);
    @(negedge clk);
    pu_write_req  = req;
    pu_write_data = d;
    wr_ready      = rdy;
    flush         = fl;
    #1;
    cyc++;
    s_ready = pu_write_ready;
    s_valid = wr_valid;
    s_busy  = busy;
    if (hold_prev) begin
      chk("hold_valid", wr_valid, 1);
      chk("hold_data", {wr_last, wr_data}, hold_val);
    end
    hold_prev = wr_valid & ~rdy;
    hold_val  = {wr_last, wr_data};
    if (flush_done) begin
      chk("flush_done_expected", model_flushing, 1);
      chk("flush_done_fifo_empty", exp_q.size() == 0, 1);
      model_flushing = 1'b0;
      fd_cyc = cyc;
    end
    if (req && !pu_write_ready) model_stall++;
    acc_seen = req & pu_write_ready;
    if (acc_seen) model_word(d);
    if (fl && !model_flushing) model_flush();
    if (wr_valid && rdy) begin
      model_pops++;
      last_pop_cyc = cyc;
      got_q.push_back({wr_last, wr_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no beat", {wr_last, wr_data});
      end else begin
        chk("pop_beat", {wr_last, wr_data}, exp_q.pop_front());
      end
    end
  endtask

  task automatic wait_flush(input string name);
    int n;
    n = 0;
    while (model_flushing && n < 100) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk({name, "_flush_done_seen"}, model_flushing, 0);
  endtask

  task automatic check_beats(input string name, input logic [BW:0] exp[$]);
    chk({name, "_count"}, got_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got_q.size()) chk(name, got_q[i], exp[i]);
    end
  endtask

  // ---------------- tests ----------------
  typedef struct {
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [BW-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  vec_t          t1[4];
  vec_t          t4[5];
  logic [BW:0]   e[$];
  logic [DW-1:0] wa, wb, wc;

  initial begin
    int acc;
    int n;

    t1[0] = '{64'd1, 64'd2, {64'd2, 64'd1}, 1'b0};
    t1[1] = '{64'd3, 64'd4, {64'd4, 64'd3}, 1'b0};
    t1[2] = '{64'd5, 64'd6, {64'd6, 64'd5}, 1'b0};
    t1[3] = '{64'd7, 64'd8, {64'd8, 64'd7}, 1'b1};
    t4[0] = '{64'h4001, 64'h4002, {64'h4002, 64'h4001}, 1'b0};
    t4[1] = '{64'h4003, 64'h4004, {64'h4004, 64'h4003}, 1'b0};
    t4[2] = '{64'h4005, 64'h4006, {64'h4006, 64'h4005}, 1'b0};
    t4[3] = '{64'h4007, 64'h4008, {64'h4008, 64'h4007}, 1'b1};
    t4[4] = '{64'h4009, 64'h400a, {64'h400a, 64'h4009}, 1'b0};

    // reset values
    reset = 1'b0; pu_write_req = 1'b0; pu_write_data = '0; flush = 1'b0; wr_ready = 1'b0;
    model_clear();
    cyc = 0; last_pop_cyc = 0; fd_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", pu_write_ready, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_last", wr_last, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_reset", s_ready, 1);

    // T1: eight words, one burst; last beat must appear one cycle after its final word
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, t1[i].w0, 1'b1, 1'b0);
      step(1'b1, t1[i].w1, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk("t1_beat", got_q[i], {t1[i].exp_last, t1[i].exp_data});
    end

    // T2: three words then flush closes a half beat
    got_q.delete();
    wa = 64'hAAAA_0000_0000_0001;
    wb = 64'hBBBB_0000_0000_0002;
    wc = 64'hCCCC_0000_0000_0003;
    step(1'b1, wa, 1'b1, 1'b0);
    step(1'b1, wb, 1'b1, 1'b0);
    step(1'b1, wc, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    wait_flush("t2");
    e.delete();
    e.push_back({1'b0, wb, wa});
    e.push_back({1'b1, 64'd0, wc});
    check_beats("t2", e);
    chk("t2_flush_done_delay", fd_cyc - last_pop_cyc, 2);

    // T3: four words then flush closes the burst with a zero beat; a second flush is empty
    got_q.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(64'h3000 + i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    wait_flush("t3");
    e.delete();
    e.push_back({1'b0, 64'h3002, 64'h3001});
    e.push_back({1'b0, 64'h3004, 64'h3003});
    e.push_back({1'b1, 128'd0});
    check_beats("t3", e);
    got_q.delete();
    step(1'b0, '0, 1'b1, 1'b1);
    wait_flush("t3_empty");
    chk("t3_empty_no_beat", got_q.size(), 0);

    // T4: back-pressure fills the FIFO after eight words, then drains in order
    got_q.delete();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, DW'(64'h4000 + acc + 1), 1'b0, 1'b0);
      if (acc_seen) acc++;
    end
    chk("t4_accepted_when_full", acc, 8);
    chk("t4_ready_low_when_full", s_ready, 0);
    n = 0;
    while (acc < 10 && n < 20) begin
      step(1'b1, DW'(64'h4000 + acc + 1), 1'b1, 1'b0);
      if (acc_seen) acc++;
      n++;
    end
    n = 0;
    while (got_q.size() < 5 && n < 20) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("t4_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk("t4_beat", got_q[i], {t4[i].exp_last, t4[i].exp_data});
    end
    step(1'b0, '0, 1'b1, 1'b1);
    wait_flush("t4");

    // T5: reset with three beats buffered discards them; next word lands in slot 0
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(64'h5000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t5_valid_before_reset", s_valid, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    pu_write_req = 1'b0; flush = 1'b0; wr_ready = 1'b0;
    model_clear();
    #1;
    chk("t5_valid_in_reset", wr_valid, 0);
    chk("t5_busy_in_reset", busy, 0);
    chk("t5_ready_in_reset", pu_write_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 64'h5555_0000_0000_00a1, 1'b1, 1'b0);
    chk("t5_ready_after_release", s_ready, 1);
    step(1'b1, 64'h5555_0000_0000_00a2, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    e.delete();
    e.push_back({1'b0, 64'h5555_0000_0000_00a2, 64'h5555_0000_0000_00a1});
    check_beats("t5", e);

    // T6: random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           {$urandom(), $urandom()},
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end
    wait_flush("t6_pre");
    step(1'b0, '0, 1'b1, 1'b1);
    wait_flush("t6_final");
    chk("t6_exp_empty", exp_q.size(), 0);
    chk("t6_idle_busy", s_busy, 0);

`ifdef PU_WRITE_PACKER_PERF_EN
    // T7: stall and pop counters
    for (int i = 0; i < 30; i++) step(1'b1, DW'(64'h7000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("t7_stall_cycles", stall_cycles, model_stall);
    chk("t7_beats_out", beats_out, model_pops);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("t7_beats_out_drained", beats_out, model_pops);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
